// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch engine: PC sequencing, memory handshake and issue to decode
// Optional feature macro: IFETCH_HALT_EN (opcode 4'hF stops fetching until reset).
module ifetch (
  input  logic        CLK,
  input  logic        RST,
  output logic [7:0]  IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_DATA,
  output logic [15:0] INSTR,
  output logic [3:0]  OP,
  output logic        IVALID,
  input  logic        ISTALL,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic [7:0]  TARGET,
  input  logic [7:0]  OFFSET,
  output logic [7:0]  PC,
  output logic        HALTED
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
`ifdef IFETCH_HALT_EN
    , HALT = 2'd3
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  pc_q, pc_nxt, pc_seq;
  logic [15:0] instr_q, instr_nxt;
  logic        consume;

  assign consume = (state == ISSUE) && !ISTALL;
  assign pc_seq  = pc_q + 8'd1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      pc_q    <= 8'h00;
      instr_q <= 16'h0000;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (IMEM_ACK) begin
          instr_nxt = IMEM_DATA;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (consume) begin
          state_nxt = FETCH;
          // Branch offset is 8-bit two's complement, so plain 8-bit add wraps correctly.
          if (JUMP)        pc_nxt = TARGET;
          else if (BRANCH) pc_nxt = pc_seq + OFFSET;
          else             pc_nxt = pc_seq;
`ifdef IFETCH_HALT_EN
          if (instr_q[15:12] == 4'hF) begin
            state_nxt = HALT;
            pc_nxt    = pc_q;
          end
`endif
        end
      end
`ifdef IFETCH_HALT_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = (state == FETCH);
  assign IVALID    = (state == ISSUE);
  assign INSTR     = instr_q;
  assign OP        = instr_q[15:12];
  assign PC        = pc_q;
`ifdef IFETCH_HALT_EN
  assign HALTED    = (state == HALT);
`else
  assign HALTED    = 1'b0;
`endif

endmodule
